// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - job sequencer feeding a skewed NxN systolic array and deskewing its results
module systolic_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   k_len,
    output logic         busy,
    output logic         done,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [N-1:0] a_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         arr_en,
    output logic         arr_clr,
    output logic [N-1:0] arr_row_in,
    input  logic [N-1:0] arr_col_out
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

    // res_valid acts as the last tag stage, so 2N-1 registers give a 2N-step latency
    localparam int TAGS = 2 * N - 1;

    state_t          state_q, state_d;
    logic [7:0]      k_len_q, acc_cnt_q, del_cnt_q;
    logic            hold, step, accept, deliver, clr;
    logic [N-1:0]    in_vec, deskew_vec, res_data_q;
    logic            res_valid_q, row0_q;
    logic [TAGS-1:0] tag_q;

    assign hold    = res_valid_q & ~res_ready;
    assign step    = ~reset & ~hold & (((state_q == S_FEED) & a_valid) | (state_q == S_FLUSH));
    assign a_ready = ~reset & ~hold & (state_q == S_FEED);
    assign accept  = a_valid & a_ready;
    assign deliver = res_valid_q & res_ready;
    assign in_vec  = (state_q == S_FEED) ? a_data : '0;
    assign clr     = reset | (state_q == S_CLEAR);

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign arr_clr   = (state_q == S_CLEAR);
    assign arr_en    = step;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Bit 0 passes straight through on a step but must still hold its value while stalled
    assign arr_row_in[0] = step ? in_vec[0] : row0_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            row0_q <= 1'b0;
        end else if (step) begin
            row0_q <= in_vec[0];
        end
    end

    for (genvar j = 1; j < N; j++) begin : g_skew
        logic [j-1:0] chain_q;
        if (j == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (clr) chain_q <= '0;
                else if (step) chain_q <= in_vec[j];
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (clr) chain_q <= '0;
                else if (step) chain_q <= {chain_q[j-2:0], in_vec[j]};
            end
        end
        assign arr_row_in[j] = chain_q[j-1];
    end

    for (genvar j = 0; j < N - 1; j++) begin : g_deskew
        localparam int L = N - 1 - j;
        logic [L-1:0] chain_q;
        if (L == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (clr) chain_q <= '0;
                else if (step) chain_q <= arr_col_out[j];
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (clr) chain_q <= '0;
                else if (step) chain_q <= {chain_q[L-2:0], arr_col_out[j]};
            end
        end
        assign deskew_vec[j] = chain_q[L-1];
    end
    assign deskew_vec[N-1] = arr_col_out[N-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (step) begin
            tag_q       <= {tag_q[TAGS-2:0], accept};
            res_valid_q <= tag_q[TAGS-1];
            if (tag_q[TAGS-1]) res_data_q <= deskew_vec;
        end else if (deliver) begin
            res_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_cnt_q <= '0;
            del_cnt_q <= '0;
        end else begin
            if (accept) acc_cnt_q <= acc_cnt_q + 8'd1;
            if (deliver) del_cnt_q <= del_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) k_len_q <= k_len;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = (k_len_q == 8'd0) ? S_DONE : S_FEED;
            S_FEED:  if (accept && (acc_cnt_q + 8'd1 == k_len_q)) state_d = S_FLUSH;
            S_FLUSH: if (deliver && (del_cnt_q + 8'd1 == k_len_q)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed scoreboard bench for systolic_sequencer with an N-stage array model
module tb_systolic_sequencer;

    localparam int N = 8;

    logic         clk, reset, start, busy, done;
    logic [7:0]   k_len;
    logic         a_valid, a_ready, res_valid, res_ready, arr_en, arr_clr;
    logic [N-1:0] a_data, res_data, arr_row_in, arr_col_out;

    int total = 0;
    int bad   = 0;
    int res_cnt = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] arr_st[N];

    systolic_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .arr_en(arr_en), .arr_clr(arr_clr),
        .arr_row_in(arr_row_in), .arr_col_out(arr_col_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array stand-in: each column is an N-stage enabled shift register
    always @(posedge clk) begin
        if (reset || arr_clr) begin
            for (int i = 0; i < N; i++) arr_st[i] <= '0;
        end else if (arr_en) begin
            arr_st[0] <= arr_row_in;
            for (int i = 1; i < N; i++) arr_st[i] <= arr_st[i-1];
        end
    end
    assign arr_col_out = arr_st[N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (a_valid && a_ready) exp_q.push_back(a_data);
            if (res_valid && res_ready) begin
                res_cnt++;
                chk("res_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] k);
        k_len = k;
        start = 1'b1;
        tick();
        chk("clear_pulse", arr_clr, 1);
        chk("clear_busy", busy, 1);
        start = 1'b0;
        tick();
        chk("clear_one_cycle", arr_clr, 0);
    endtask

    task automatic feed(input int k, input bit bubble, input logic [7:0] base);
        int sent = 0;
        int guard = 0;
        logic acc;
        logic have_bub = 1'b0;
        logic [N-1:0] prev, bub;
        while (sent < k && guard < 500) begin
            a_valid = 1'b1;
            a_data  = base + 8'(sent);
            #1;
            if (have_bub) chk("bubble_row_hold", bub[N-1:1], arr_row_in[N-1:1]);
            have_bub = 1'b0;
            prev = arr_row_in;
            acc  = a_ready;
            tick();
            guard++;
            if (acc) sent++;
            if (bubble && sent < k) begin
                a_valid = 1'b0;
                a_data  = ~a_data;
                #1;
                chk("bubble_arr_en", arr_en, 0);
                chk("bubble_row0", arr_row_in[0], prev[0]);
                bub = arr_row_in;
                have_bub = 1'b1;
                tick();
                guard++;
            end
        end
        a_valid = 1'b0;
        chk("feed_count", sent, k);
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("wait_res", res_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
        tick();
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n, base_cnt;
        logic [N-1:0] rd;

        reset = 1'b1; start = 1'b0; k_len = '0;
        a_valid = 1'b0; a_data = '0; res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_arr_en", arr_en, 0);
        chk("rst_arr_clr", arr_clr, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_row_in", arr_row_in, 0);
        reset = 1'b0;
        tick();

        // single vector with latency measurement
        start_job(8'd1);
        a_valid = 1'b1; a_data = 8'hA5;
        #1;
        chk("single_a_ready", a_ready, 1);
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("single_latency", n, 16);
        chk("single_res_data", res_data, 8'hA5);
        tick();
        chk("single_valid_one_cycle", res_valid, 0);
        chk("single_done", done, 1);
        tick();
        chk("single_done_pulse", done, 0);
        chk("single_idle", busy, 0);
        a_valid = 1'b0;

        // streaming 20 vectors
        base_cnt = res_cnt;
        start_job(8'd20);
        fork
            begin
                feed(20, 1'b0, 8'h01);
                chk("stream_a_ready_low", a_ready, 0);
            end
            begin
                wait_res();
                for (int i = 0; i < 20; i++) begin
                    chk("stream_consec", res_valid, 1);
                    tick();
                end
                chk("stream_done", done, 1);
                tick();
                chk("stream_busy_drop", busy, 0);
            end
        join
        chk("stream_count", res_cnt - base_cnt, 20);

        // backpressure
        base_cnt = res_cnt;
        start_job(8'd4);
        feed(4, 1'b0, 8'h01);
        wait_res();
        res_ready = 1'b0;
        #1;
        rd = res_data;
        for (int i = 0; i < 5; i++) begin
            chk("bp_arr_en", arr_en, 0);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_res_data", res_data, rd);
            chk("bp_res_valid", res_valid, 1);
            tick();
        end
        res_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_count", res_cnt - base_cnt, 4);

        // input bubbles
        base_cnt = res_cnt;
        start_job(8'd4);
        feed(4, 1'b1, 8'h41);
        wait_done("bubble_done");
        chk("bubble_count", res_cnt - base_cnt, 4);

        // zero length, with a start during DONE that must be ignored
        base_cnt = res_cnt;
        k_len = 8'd0;
        start = 1'b1;
        tick();
        chk("zero_clear", arr_clr, 1);
        chk("zero_clear_en", arr_en, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_arr_en", arr_en, 0);
        chk("zero_res_valid", res_valid, 0);
        tick();
        start = 1'b0;
        chk("zero_start_ignored", busy, 0);
        tick();
        chk("zero_no_results", res_cnt - base_cnt, 0);

        // reset in FLUSH with a result pending
        res_ready = 1'b0;
        start_job(8'd2);
        feed(2, 1'b0, 8'h11);
        wait_res();
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_arr_en", arr_en, 0);
        chk("mid_rst_arr_clr", arr_clr, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_row_in", arr_row_in, 0);
        reset = 1'b0;
        res_ready = 1'b1;
        tick();
        base_cnt = res_cnt;
        start_job(8'd1);
        feed(1, 1'b0, 8'h3C);
        wait_done("post_rst_done");
        chk("post_rst_count", res_cnt - base_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
